led_frame_rx: RTL

LED_FRAME_RX -- requirements
Module: led_frame_rx

---
 rtl/led_frame_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_frame_rx.sv
// Serial LED-chain receiver: synchronizes cko/sdo, hunts for a 32-zero start frame,
// then decodes NUM_LED 32-bit words into brightness/colour strobes.
module led_frame_rx #(
    parameter int NUM_LED = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       cko_i,
    input  logic       sdo_i,
    output logic       pix_valid,
    output logic [2:0] pix_idx,
    output logic [4:0] pix_bri,
    output logic [7:0] pix_b,
    output logic [7:0] pix_g,
    output logic [7:0] pix_r,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int IDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, WORD, TAIL} state_t;

    state_t          r_state;
    logic            r_cko_s1, r_cko_s2, r_cko_d;
    logic            r_sdo_s1, r_sdo_s2;
    logic [IDW-1:0]  r_idle;
    logic [5:0]      r_zeros;
    logic [4:0]      r_bitcnt;
    logic [30:0]     r_shift;
    logic [2:0]      r_led;

    logic            w_edge;
    logic            w_bit;
    logic            w_timeout;
    logic [31:0]     w_word;

    assign w_edge    = r_cko_s2 & ~r_cko_d;
    assign w_bit     = r_sdo_s2;
    assign w_timeout = (r_idle == IDW'(TIMEOUT));
    // Shift register keeps the 31 earlier bits; the word is completed by the current sample.
    assign w_word    = {r_shift, w_bit};
    assign busy      = (r_state != HUNT);

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_cko_s1 <= 1'b0;
            r_cko_s2 <= 1'b0;
            r_cko_d  <= 1'b0;
            r_sdo_s1 <= 1'b0;
            r_sdo_s2 <= 1'b0;
        end else begin
            r_cko_s1 <= cko_i;
            r_cko_s2 <= r_cko_s1;
            r_cko_d  <= r_cko_s2;
            r_sdo_s1 <= sdo_i;
            r_sdo_s2 <= r_sdo_s1;
        end
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_edge) begin
            r_idle <= '0;
        end else if (!w_timeout) begin
            r_idle <= r_idle + IDW'(1);
        end
    end

    // An edge always wins over a simultaneous timeout so the first bit after a long gap is kept.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_zeros    <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_led      <= '0;
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            pix_bri    <= '0;
            pix_b      <= '0;
            pix_g      <= '0;
            pix_r      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_edge) begin
                        if (w_bit) begin
                            if (r_zeros == 6'd32) begin
                                r_state  <= WORD;
                                r_shift  <= 31'd1;
                                r_bitcnt <= 5'd1;
                                r_led    <= '0;
                            end
                            r_zeros <= '0;
                        end else if (r_zeros != 6'd32) begin
                            r_zeros <= r_zeros + 6'd1;
                        end
                    end else if (w_timeout) begin
                        r_zeros <= '0;
                    end
                end
                WORD: begin
                    if (w_edge) begin
                        r_shift  <= w_word[30:0];
                        r_bitcnt <= r_bitcnt + 5'd1;
                        if (r_bitcnt == 5'd31) begin
                            if (w_word[31:29] == 3'b111) begin
                                pix_valid <= 1'b1;
                                pix_idx   <= r_led;
                                pix_bri   <= w_word[28:24];
                                pix_b     <= w_word[23:16];
                                pix_g     <= w_word[15:8];
                                pix_r     <= w_word[7:0];
                                r_led     <= r_led + 3'd1;
                                if (r_led == 3'(NUM_LED - 1)) begin
                                    frame_done <= 1'b1;
                                    r_state    <= TAIL;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= HUNT;
                                r_zeros   <= '0;
                            end
                        end
                    end else if (w_timeout) begin
                        frame_err <= 1'b1;
                        r_state   <= HUNT;
                        r_zeros   <= '0;
                    end
                end
                TAIL: begin
                    if (!w_edge && w_timeout) begin
                        r_state <= HUNT;
                        r_zeros <= '0;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

endmodule
